// File: rtl/axi_dma_pkg.sv
// axi_dma_pkg: shared encodings and state type for the AXI DMA engines.
// Holds the AXI burst/response encodings, the 4 KB burst-boundary size and
// the write-engine FSM state enum.
package axi_dma_pkg;

   // AXI AWBURST/ARBURST encoding for incrementing bursts
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   // AXI BRESP/RRESP encoding for a normal, successful access
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   // AXI bursts must never cross a 4 KB address boundary
   localparam int BOUNDARY_4K = 4096;

   // Write-engine control states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WRITE,
      ST_PAD,
      ST_DROP,
      ST_WAIT_B
   } dma_wr_state_t;

endpackage

// File: rtl/axi_dma_wr.sv
// axi_dma_wr: stream-to-memory DMA write engine (aligned transfers only).
// Takes a descriptor (addr, byte len, tag), consumes one AXI stream frame and
// writes it through an AXI4 write master in bursts of at most
// AXI_MAX_BURST_LEN beats that never cross a 4 KB boundary. A status pulse is
// emitted once every issued burst has received its write response.
// Optional feature macro: AXI_DMA_WR_BRESP_CHECK_EN -- when defined, any
// non-OKAY bresp during a transfer is reported on status_error; otherwise
// status_error is tied low and bresp is ignored.
module axi_dma_wr
   import axi_dma_pkg::*;
#(
   parameter int AXI_DATA_WIDTH    = 32,
   parameter int AXI_ADDR_WIDTH    = 16,
   parameter int AXI_STRB_WIDTH    = AXI_DATA_WIDTH / 8,
   parameter int AXI_ID_WIDTH      = 8,
   parameter int AXI_MAX_BURST_LEN = 16,
   parameter int AXIS_ID_WIDTH     = 8,
   parameter int AXIS_USER_WIDTH   = 1,
   parameter int LEN_WIDTH         = 20,
   parameter int TAG_WIDTH         = 8
) (
   input  logic                       clk,
   input  logic                       rst,

   input  logic [AXI_ADDR_WIDTH-1:0]  s_axis_write_desc_addr,
   input  logic [LEN_WIDTH-1:0]       s_axis_write_desc_len,
   input  logic [TAG_WIDTH-1:0]       s_axis_write_desc_tag,
   input  logic                       s_axis_write_desc_valid,
   output logic                       s_axis_write_desc_ready,

   output logic [LEN_WIDTH-1:0]       m_axis_write_desc_status_len,
   output logic [TAG_WIDTH-1:0]       m_axis_write_desc_status_tag,
   output logic [AXIS_ID_WIDTH-1:0]   m_axis_write_desc_status_id,
   output logic [AXIS_USER_WIDTH-1:0] m_axis_write_desc_status_user,
   output logic                       m_axis_write_desc_status_error,
   output logic                       m_axis_write_desc_status_valid,

   input  logic [AXI_DATA_WIDTH-1:0]  s_axis_write_data_tdata,
   input  logic [AXI_STRB_WIDTH-1:0]  s_axis_write_data_tkeep,
   input  logic                       s_axis_write_data_tvalid,
   output logic                       s_axis_write_data_tready,
   input  logic                       s_axis_write_data_tlast,
   input  logic [AXIS_ID_WIDTH-1:0]   s_axis_write_data_tid,
   input  logic [AXIS_USER_WIDTH-1:0] s_axis_write_data_tuser,

   output logic [AXI_ID_WIDTH-1:0]    m_axi_awid,
   output logic [AXI_ADDR_WIDTH-1:0]  m_axi_awaddr,
   output logic [7:0]                 m_axi_awlen,
   output logic [2:0]                 m_axi_awsize,
   output logic [1:0]                 m_axi_awburst,
   output logic                       m_axi_awlock,
   output logic [3:0]                 m_axi_awcache,
   output logic [2:0]                 m_axi_awprot,
   output logic                       m_axi_awvalid,
   input  logic                       m_axi_awready,
   output logic [AXI_DATA_WIDTH-1:0]  m_axi_wdata,
   output logic [AXI_STRB_WIDTH-1:0]  m_axi_wstrb,
   output logic                       m_axi_wlast,
   output logic                       m_axi_wvalid,
   input  logic                       m_axi_wready,
   input  logic [AXI_ID_WIDTH-1:0]    m_axi_bid,
   input  logic [1:0]                 m_axi_bresp,
   input  logic                       m_axi_bvalid,
   output logic                       m_axi_bready,

   input  logic                       enable
);

   localparam int ADDR_SHIFT = $clog2(AXI_STRB_WIDTH);
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LOW_MASK = AXI_ADDR_WIDTH'(AXI_STRB_WIDTH - 1);
   localparam logic [LEN_WIDTH-1:0] STRB_BYTES = LEN_WIDTH'(AXI_STRB_WIDTH);

   // Beats for the next burst: limited by what is left, the burst cap and the
   // distance to the next 4 KB boundary (never zero for an aligned address).
   function automatic logic [8:0] burst_beats(input logic [AXI_ADDR_WIDTH-1:0] a,
                                              input logic [LEN_WIDTH-1:0] rem);
      logic [12:0]          to_bound;
      logic [LEN_WIDTH-1:0] n;
      to_bound = (13'(BOUNDARY_4K) - {1'b0, a[11:0]}) >> ADDR_SHIFT;
      n = rem;
      if (n > LEN_WIDTH'(AXI_MAX_BURST_LEN)) n = LEN_WIDTH'(AXI_MAX_BURST_LEN);
      if (n > LEN_WIDTH'(to_bound)) n = LEN_WIDTH'(to_bound);
      return 9'(n);
   endfunction

   // Number of bytes actually written in one beat
   function automatic logic [LEN_WIDTH-1:0] popcount(input logic [AXI_STRB_WIDTH-1:0] v);
      logic [LEN_WIDTH-1:0] c;
      c = '0;
      for (int i = 0; i < AXI_STRB_WIDTH; i++) c = c + LEN_WIDTH'(v[i]);
      return c;
   endfunction

   dma_wr_state_t              state_reg, state_next;
   logic [AXI_ADDR_WIDTH-1:0]  addr_reg, addr_next;
   logic [LEN_WIDTH-1:0]       beats_rem_reg, beats_rem_next;
   logic [LEN_WIDTH-1:0]       bytes_left_reg, bytes_left_next;
   logic [LEN_WIDTH-1:0]       byte_cnt_reg, byte_cnt_next;
   logic [8:0]                 burst_cnt_reg, burst_cnt_next;
   logic [TAG_WIDTH-1:0]       tag_reg, tag_next;
   logic                       first_beat_reg, first_beat_next;
   logic [AXIS_ID_WIDTH-1:0]   axis_id_reg, axis_id_next;
   logic [AXIS_USER_WIDTH-1:0] axis_user_reg, axis_user_next;
   logic [7:0]                 outstanding_reg, outstanding_next;
   logic                       err_next;

   logic [LEN_WIDTH-1:0]       status_len_reg, status_len_next;
   logic [TAG_WIDTH-1:0]       status_tag_reg, status_tag_next;
   logic [AXIS_ID_WIDTH-1:0]   status_id_reg, status_id_next;
   logic [AXIS_USER_WIDTH-1:0] status_user_reg, status_user_next;
   logic                       status_error_reg, status_error_next;
   logic                       status_valid_reg, status_valid_next;

   logic [8:0]                 cur_burst_beats;
   logic [LEN_WIDTH:0]         desc_len_round;
   logic [LEN_WIDTH-1:0]       desc_beats;
   logic [AXI_STRB_WIDTH-1:0]  len_mask;
   logic [AXI_STRB_WIDTH-1:0]  wstrb_write;
   logic                       desc_fire;
   logic                       aw_fire;
   logic                       b_fire;
   logic                       beat_fire;

   assign cur_burst_beats = burst_beats(addr_reg, beats_rem_reg);
   assign desc_len_round  = {1'b0, s_axis_write_desc_len} + (LEN_WIDTH + 1)'(AXI_STRB_WIDTH - 1);
   assign desc_beats      = (s_axis_write_desc_len == '0) ? LEN_WIDTH'(1)
                                                          : LEN_WIDTH'(desc_len_round >> ADDR_SHIFT);

   // Byte lane is written only while it still lies inside the descriptor length
   for (genvar gi = 0; gi < AXI_STRB_WIDTH; gi++) begin : g_lane
      assign len_mask[gi] = (bytes_left_reg > LEN_WIDTH'(gi));
   end
   assign wstrb_write = s_axis_write_data_tkeep & len_mask;

   // The status pulse cycle is kept out of IDLE acceptance so the next
   // descriptor is taken no earlier than the cycle after it.
   assign s_axis_write_desc_ready = (state_reg == ST_IDLE) && enable && !status_valid_reg && !rst;

   assign desc_fire = s_axis_write_desc_valid && s_axis_write_desc_ready;
   assign aw_fire   = m_axi_awvalid && m_axi_awready;
   assign b_fire    = m_axi_bvalid;
   assign beat_fire = s_axis_write_data_tvalid && m_axi_wready;

   assign m_axi_awid    = '0;
   assign m_axi_awaddr  = addr_reg;
   assign m_axi_awlen   = 8'(cur_burst_beats - 9'd1);
   assign m_axi_awsize  = 3'(ADDR_SHIFT);
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_bready  = 1'b1;

   assign m_axis_write_desc_status_len   = status_len_reg;
   assign m_axis_write_desc_status_tag   = status_tag_reg;
   assign m_axis_write_desc_status_id    = status_id_reg;
   assign m_axis_write_desc_status_user  = status_user_reg;
   assign m_axis_write_desc_status_error = status_error_reg;
   assign m_axis_write_desc_status_valid = status_valid_reg;

   // Outstanding-burst count: +1 per AW, -1 per B (stray B after a reset ignored)
   always_comb begin
      outstanding_next = outstanding_reg;
      if (aw_fire && !(b_fire && outstanding_reg != 8'd0))
         outstanding_next = outstanding_reg + 8'd1;
      else if (!aw_fire && b_fire && outstanding_reg != 8'd0)
         outstanding_next = outstanding_reg - 8'd1;
   end

`ifdef AXI_DMA_WR_BRESP_CHECK_EN
   logic err_reg;
   logic unused_inputs;
   assign unused_inputs = &{1'b0, m_axi_bid};

   // Sticky error flag: any non-OKAY response during a transfer, cleared in IDLE
   always_comb begin
      err_next = err_reg;
      if (state_reg == ST_IDLE)
         err_next = 1'b0;
      else if (b_fire && m_axi_bresp != AXI_RESP_OKAY)
         err_next = 1'b1;
   end

   // Error flag register
   always_ff @(posedge clk) begin
      if (rst) err_reg <= 1'b0;
      else     err_reg <= err_next;
   end
`else
   logic unused_inputs;
   assign unused_inputs = &{1'b0, m_axi_bid, m_axi_bresp};
   assign err_next      = 1'b0;
`endif

   // Next-state, W pass-through and AW request logic
   always_comb begin
      state_next        = state_reg;
      addr_next         = addr_reg;
      beats_rem_next    = beats_rem_reg;
      bytes_left_next   = bytes_left_reg;
      byte_cnt_next     = byte_cnt_reg;
      burst_cnt_next    = burst_cnt_reg;
      tag_next          = tag_reg;
      first_beat_next   = first_beat_reg;
      axis_id_next      = axis_id_reg;
      axis_user_next    = axis_user_reg;
      status_len_next   = status_len_reg;
      status_tag_next   = status_tag_reg;
      status_id_next    = status_id_reg;
      status_user_next  = status_user_reg;
      status_error_next = status_error_reg;
      status_valid_next = 1'b0;
      m_axi_awvalid     = 1'b0;
      m_axi_wvalid      = 1'b0;
      m_axi_wdata       = '0;
      m_axi_wstrb       = '0;
      m_axi_wlast       = 1'b0;
      s_axis_write_data_tready = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (desc_fire) begin
               addr_next       = s_axis_write_desc_addr & ~ADDR_LOW_MASK;
               beats_rem_next  = desc_beats;
               bytes_left_next = s_axis_write_desc_len;
               byte_cnt_next   = '0;
               tag_next        = s_axis_write_desc_tag;
               first_beat_next = 1'b1;
               state_next      = ST_START;
            end
         end
         ST_START: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) begin
               addr_next      = addr_reg + (AXI_ADDR_WIDTH'(cur_burst_beats) << ADDR_SHIFT);
               beats_rem_next = beats_rem_reg - LEN_WIDTH'(cur_burst_beats);
               burst_cnt_next = cur_burst_beats;
               state_next     = ST_WRITE;
            end
         end
         ST_WRITE: begin
            s_axis_write_data_tready = m_axi_wready;
            m_axi_wvalid = s_axis_write_data_tvalid;
            m_axi_wdata  = s_axis_write_data_tdata;
            m_axi_wstrb  = wstrb_write;
            m_axi_wlast  = (burst_cnt_reg == 9'd1);
            if (beat_fire) begin
               burst_cnt_next  = burst_cnt_reg - 9'd1;
               bytes_left_next = (bytes_left_reg > STRB_BYTES) ? bytes_left_reg - STRB_BYTES : '0;
               byte_cnt_next   = byte_cnt_reg + popcount(wstrb_write);
               if (first_beat_reg) begin
                  first_beat_next = 1'b0;
                  axis_id_next    = s_axis_write_data_tid;
                  axis_user_next  = s_axis_write_data_tuser;
               end
               if (burst_cnt_reg == 9'd1) begin
                  // Frame ending on a burst boundary stops further bursts
                  if (s_axis_write_data_tlast)
                     state_next = ST_WAIT_B;
                  else if (beats_rem_reg != '0)
                     state_next = ST_START;
                  else
                     state_next = ST_DROP;
               end else if (s_axis_write_data_tlast) begin
                  state_next = ST_PAD;
               end
            end
         end
         ST_PAD: begin
            m_axi_wvalid = 1'b1;
            m_axi_wlast  = (burst_cnt_reg == 9'd1);
            if (m_axi_wready) begin
               burst_cnt_next = burst_cnt_reg - 9'd1;
               if (burst_cnt_reg == 9'd1) state_next = ST_WAIT_B;
            end
         end
         ST_DROP: begin
            s_axis_write_data_tready = 1'b1;
            if (s_axis_write_data_tvalid && s_axis_write_data_tlast) state_next = ST_WAIT_B;
         end
         ST_WAIT_B: begin
            if (outstanding_next == 8'd0) begin
               status_valid_next = 1'b1;
               status_len_next   = byte_cnt_reg;
               status_tag_next   = tag_reg;
               status_id_next    = axis_id_reg;
               status_user_next  = axis_user_reg;
               status_error_next = err_next;
               state_next        = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         addr_reg         <= '0;
         beats_rem_reg    <= '0;
         bytes_left_reg   <= '0;
         byte_cnt_reg     <= '0;
         burst_cnt_reg    <= '0;
         tag_reg          <= '0;
         first_beat_reg   <= 1'b0;
         axis_id_reg      <= '0;
         axis_user_reg    <= '0;
         outstanding_reg  <= '0;
         status_len_reg   <= '0;
         status_tag_reg   <= '0;
         status_id_reg    <= '0;
         status_user_reg  <= '0;
         status_error_reg <= 1'b0;
         status_valid_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         addr_reg         <= addr_next;
         beats_rem_reg    <= beats_rem_next;
         bytes_left_reg   <= bytes_left_next;
         byte_cnt_reg     <= byte_cnt_next;
         burst_cnt_reg    <= burst_cnt_next;
         tag_reg          <= tag_next;
         first_beat_reg   <= first_beat_next;
         axis_id_reg      <= axis_id_next;
         axis_user_reg    <= axis_user_next;
         outstanding_reg  <= outstanding_next;
         status_len_reg   <= status_len_next;
         status_tag_reg   <= status_tag_next;
         status_id_reg    <= status_id_next;
         status_user_reg  <= status_user_next;
         status_error_reg <= status_error_next;
         status_valid_reg <= status_valid_next;
      end
   end

endmodule

// File: tb/tb_axi_dma_wr.sv
// tb_axi_dma_wr: randomized scoreboard bench for axi_dma_wr.
// Stimulus computes the expected AW/W/status traffic from descriptor and frame
// contents and queues it; a single monitor pops and compares on handshakes.
module tb_axi_dma_wr;

   logic        clk;
   logic        rst;
   logic [15:0] desc_addr;
   logic [19:0] desc_len;
   logic [7:0]  desc_tag;
   logic        desc_valid, desc_ready;
   logic [19:0] st_len;
   logic [7:0]  st_tag, st_id;
   logic        st_user, st_error, st_valid;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tvalid, tready, tlast;
   logic [7:0]  tid;
   logic        tuser;
   logic [7:0]  awid;
   logic [15:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize, awprot;
   logic [1:0]  awburst, bresp;
   logic        awlock, awvalid, awready;
   logic [3:0]  awcache;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [7:0]  bid;
   logic        bvalid, bready;
   logic        enable;

   axi_dma_wr #(
      .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16), .AXI_STRB_WIDTH(4), .AXI_ID_WIDTH(8),
      .AXI_MAX_BURST_LEN(16), .AXIS_ID_WIDTH(8), .AXIS_USER_WIDTH(1),
      .LEN_WIDTH(20), .TAG_WIDTH(8)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_write_desc_addr(desc_addr), .s_axis_write_desc_len(desc_len),
      .s_axis_write_desc_tag(desc_tag), .s_axis_write_desc_valid(desc_valid),
      .s_axis_write_desc_ready(desc_ready),
      .m_axis_write_desc_status_len(st_len), .m_axis_write_desc_status_tag(st_tag),
      .m_axis_write_desc_status_id(st_id), .m_axis_write_desc_status_user(st_user),
      .m_axis_write_desc_status_error(st_error), .m_axis_write_desc_status_valid(st_valid),
      .s_axis_write_data_tdata(tdata), .s_axis_write_data_tkeep(tkeep),
      .s_axis_write_data_tvalid(tvalid), .s_axis_write_data_tready(tready),
      .s_axis_write_data_tlast(tlast), .s_axis_write_data_tid(tid),
      .s_axis_write_data_tuser(tuser),
      .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
      .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
      .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .enable(enable)
   );

   typedef struct packed { logic [15:0] addr; logic [7:0] len; } aw_exp_t;
   typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_exp_t;
   typedef struct packed { logic [19:0] len; logic [7:0] tag; logic [7:0] id; logic user; logic err; } st_exp_t;

   aw_exp_t    aw_q[$];
   w_exp_t     w_q[$];
   st_exp_t    st_q[$];
   logic [1:0] bresp_plan[$];

   int n_cmp = 0;
   int n_err = 0;
   int wlast_cnt = 0;
   int b_sent = 0;
   int status_cnt = 0;
   int txn_cnt = 0;
   int timeout_cnt = 0;
   bit tb_done = 0;
   bit throttle = 0;
   bit rand_en = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, got, exp);
      end
   endtask

   // Slave readiness and enable toggling
   initial begin
      awready = 1'b0;
      wready  = 1'b0;
      enable  = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         awready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         wready  = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
         enable  = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Write-response driver: one B per completed burst, in order
   initial begin
      bvalid = 1'b0;
      bresp  = 2'b00;
      bid    = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         bvalid = 1'b0;
         if (!rst && wlast_cnt > b_sent && (!throttle || $urandom_range(0, 2) == 0)) begin
            bresp  = (bresp_plan.size() != 0) ? bresp_plan.pop_front() : 2'b00;
            bvalid = 1'b1;
            b_sent++;
         end
      end
   end

   // Monitor / scoreboard: the only process that compares
   initial begin
      bit prev_desc_fire;
      aw_exp_t ea;
      w_exp_t  ew;
      st_exp_t es;
      prev_desc_fire = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_desc_ready", 64'(desc_ready), 64'(0));
      chk("rst_awvalid", 64'(awvalid), 64'(0));
      chk("rst_wvalid", 64'(wvalid), 64'(0));
      chk("rst_tready", 64'(tready), 64'(0));
      chk("rst_status_valid", 64'(st_valid), 64'(0));
      chk("rst_status_fields", 64'({st_len, st_tag, st_id, st_user, st_error}), 64'(0));
      chk("rst_bready", 64'(bready), 64'(1));
      forever begin
         @(negedge clk);
         if (tb_done) begin
            chk("timeout", 64'(timeout_cnt), 64'(0));
            chk("aw_left", 64'(aw_q.size()), 64'(0));
            chk("w_left", 64'(w_q.size()), 64'(0));
            chk("status_left", 64'(st_q.size()), 64'(0));
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
         end
         if (!rst) begin
            if (prev_desc_fire) chk("aw_after_accept", 64'(awvalid), 64'(1));
            prev_desc_fire = desc_valid && desc_ready;
            if (prev_desc_fire) chk("desc_enable", 64'(enable), 64'(1));
            if (awvalid && awready) begin
               if (aw_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL aw_unexpected: got addr %0h len %0d, want none", awaddr, awlen);
               end else begin
                  ea = aw_q.pop_front();
                  $display("AW  addr=%04h len=%0d", awaddr, awlen);
                  chk("awaddr", 64'(awaddr), 64'(ea.addr));
                  chk("awlen", 64'(awlen), 64'(ea.len));
                  chk("aw_const", 64'({awid, awsize, awburst, awlock, awcache, awprot}),
                      64'({8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}));
               end
            end
            if (wvalid && wready) begin
               if (wlast) wlast_cnt++;
               if (w_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL w_unexpected: got data %0h strb %0h, want none", wdata, wstrb);
               end else begin
                  ew = w_q.pop_front();
                  chk("wdata", 64'(wdata), 64'(ew.data));
                  chk("wstrb", 64'(wstrb), 64'(ew.strb));
                  chk("wlast", 64'(wlast), 64'(ew.last));
               end
            end
            if (st_valid) begin
               status_cnt++;
               if (st_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL status_unexpected: got len %0d, want none", st_len);
               end else begin
                  es = st_q.pop_front();
                  $display("STATUS len=%0d tag=%02h id=%02h user=%0d err=%0d", st_len, st_tag, st_id, st_user, st_error);
                  chk("status_len", 64'(st_len), 64'(es.len));
                  chk("status_tag", 64'(st_tag), 64'(es.tag));
                  chk("status_id", 64'(st_id), 64'(es.id));
                  chk("status_user", 64'(st_user), 64'(es.user));
                  chk("status_error", 64'(st_error), 64'(es.err));
               end
            end
         end
      end
   end

   task automatic abort_run();
      timeout_cnt++;
      tb_done = 1'b1;
      forever @(posedge clk);
   endtask

   // One transfer: build frame, derive expected traffic, then drive it
   task automatic run_txn(input logic [15:0] addr, input int len, input int nbeats,
                          input bit keep_rand, input bit slverr);
      logic [31:0] fdata[64];
      logic [3:0]  fkeep[64];
      logic [7:0]  fid[64];
      logic        fuser[64];
      logic [7:0]  tag;
      logic [3:0]  m;
      int a, total, rem, k, b, to_b, bytes, cnt, gaps;
      bit first_burst;
      aw_exp_t aw;
      w_exp_t  w;
      st_exp_t st;

      for (int i = 0; i < nbeats; i++) begin
         fdata[i] = $urandom;
         fkeep[i] = keep_rand ? 4'($urandom_range(0, 15)) : 4'hF;
         fid[i]   = 8'($urandom);
         fuser[i] = 1'($urandom);
      end
      tag = 8'($urandom);

      // Reference: bursts follow the length/cap/4 KB rules; a burst is only
      // issued while the frame has not ended; beats past tlast are padding.
      a = int'(addr) & 'hFFFC;
      total = (len == 0) ? 1 : (len + 3) / 4;
      rem = total; k = 0; bytes = 0; first_burst = 1'b1;
      while (rem > 0 && k < nbeats) begin
         b = (rem < 16) ? rem : 16;
         to_b = (4096 - (a % 4096)) / 4;
         if (b > to_b) b = to_b;
         aw.addr = 16'(a);
         aw.len  = 8'(b - 1);
         aw_q.push_back(aw);
         bresp_plan.push_back((slverr && first_burst) ? 2'b10 : 2'b00);
         first_burst = 1'b0;
         for (int j = 0; j < b; j++) begin
            if (k < nbeats) begin
               m = '0;
               for (int i = 0; i < 4; i++) if (4 * k + i < len) m[i] = 1'b1;
               w.data = fdata[k];
               w.strb = fkeep[k] & m;
               bytes += $countones(w.strb);
            end else begin
               w.data = '0;
               w.strb = '0;
            end
            w.last = (j == b - 1);
            w_q.push_back(w);
            k++;
         end
         a = (a + 4 * b) & 'hFFFF;
         rem -= b;
      end
      st.len  = 20'(bytes);
      st.tag  = tag;
      st.id   = fid[0];
      st.user = fuser[0];
`ifdef AXI_DMA_WR_BRESP_CHECK_EN
      st.err  = slverr;
`else
      st.err  = 1'b0;
`endif
      st_q.push_back(st);
      txn_cnt++;
      $display("DESC addr=%04h len=%0d beats=%0d slverr=%0d -> exp status len %0d", addr, len, nbeats, slverr, bytes);

      @(posedge clk);
      #1;
      desc_addr = addr; desc_len = 20'(len); desc_tag = tag; desc_valid = 1'b1;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (desc_ready) break;
         cnt++;
         if (cnt > 4000) abort_run();
      end
      @(posedge clk);
      #1;
      desc_valid = 1'b0;

      for (int i = 0; i < nbeats; i++) begin
         if (throttle) begin
            gaps = $urandom_range(0, 2);
            repeat (gaps) begin tvalid = 1'b0; @(posedge clk); #1; end
         end
         tvalid = 1'b1; tdata = fdata[i]; tkeep = fkeep[i]; tid = fid[i]; tuser = fuser[i];
         tlast  = (i == nbeats - 1);
         cnt = 0;
         forever begin
            @(negedge clk);
            if (tready) break;
            cnt++;
            if (cnt > 4000) abort_run();
         end
         @(posedge clk);
         #1;
      end
      tvalid = 1'b0;
      tlast  = 1'b0;

      cnt = 0;
      while (status_cnt < txn_cnt) begin
         @(negedge clk);
         cnt++;
         if (cnt > 4000) abort_run();
      end
   endtask

   // Main stimulus: directed cases, then throttled random transfers
   initial begin
      int len, total, nb;
      logic [15:0] addr;
      rst = 1'b1;
      desc_addr = '0; desc_len = '0; desc_tag = '0; desc_valid = 1'b0;
      tdata = '0; tkeep = '0; tvalid = 1'b0; tlast = 1'b0; tid = '0; tuser = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;

      run_txn(16'h0000, 64, 16, 1'b0, 1'b0);
      run_txn(16'h0FF8, 32, 8, 1'b0, 1'b0);
      run_txn(16'h0100, 40, 4, 1'b0, 1'b0);
      run_txn(16'h0200, 8, 5, 1'b0, 1'b0);
      run_txn(16'h0300, 6, 2, 1'b0, 1'b0);
      run_txn(16'h0400, 64, 16, 1'b0, 1'b1);
      run_txn(16'h0500, 0, 1, 1'b0, 1'b0);
      run_txn(16'h1FC3, 100, 25, 1'b0, 1'b0);

      throttle = 1'b1;
      rand_en  = 1'b1;
      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(0, 2) == 0)
            addr = 16'(($urandom_range(0, 14) << 12) | ('h1000 - 4 * $urandom_range(1, 8)));
         else
            addr = 16'($urandom_range(0, 'hEFFF));
         len   = $urandom_range(0, 200);
         total = (len == 0) ? 1 : (len + 3) / 4;
         nb    = total + $urandom_range(0, 6) - 3;
         if (nb < 1) nb = 1;
         run_txn(addr, len, nb, 1'($urandom), $urandom_range(0, 5) == 0);
      end
      throttle = 1'b0;
      rand_en  = 1'b0;
      repeat (20) @(posedge clk);
      tb_done = 1'b1;
   end

endmodule
